// File: rtl/regfile_pkg.sv
// Shared types and default sizing for the parametrised register file.
package regfile_pkg;
  typedef enum logic {RF_CLEAR, RF_READY} rf_state_t;

  localparam int RF_XLEN  = 32;
  localparam int RF_DEPTH = 32;
  localparam int RF_NREAD = 2;
endpackage

// File: rtl/regfile_clear_fsm.sv
// Clear engine: sweeps every entry to zero after reset or on clear_req, then flags ready.
module regfile_clear_fsm
  import regfile_pkg::*;
#(
  parameter int DEPTH = RF_DEPTH,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear_req,
  output logic          ready,
  output logic          clear_done,
  output logic          clr_we,
  output logic [AW-1:0] clr_addr
);

  rf_state_t     state;
  logic [AW-1:0] clr_idx;
  logic          last;

  assign last = (clr_idx == AW'(DEPTH - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= RF_CLEAR;
      clr_idx <= '0;
      ready   <= 1'b0;
    end else begin
      case (state)
        RF_CLEAR: begin
          // Exit before clr_idx would wrap past DEPTH-1.
          if (last) begin
            state   <= RF_READY;
            ready   <= 1'b1;
            clr_idx <= '0;
          end else begin
            clr_idx <= clr_idx + AW'(1);
          end
        end
        RF_READY: begin
          if (clear_req) begin
            state   <= RF_CLEAR;
            ready   <= 1'b0;
            clr_idx <= '0;
          end
        end
        default: begin
          state   <= RF_CLEAR;
          ready   <= 1'b0;
          clr_idx <= '0;
        end
      endcase
    end
  end

  // Pulse marks the cycle whose edge writes the final entry; ready follows one cycle later.
  assign clr_we     = (state == RF_CLEAR) && !reset;
  assign clr_addr   = clr_idx;
  assign clear_done = clr_we && last;

endmodule

// File: rtl/regfile_mp.sv
// Multi-read-port integer register file with optional write bypass and a sequential clear.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int XLEN     = RF_XLEN,
  parameter int DEPTH    = RF_DEPTH,
  parameter int NREAD    = RF_NREAD,
  parameter bit BYPASS   = 1'b1,
  parameter bit ZERO_REG = 1'b1,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear_req,
  input  logic                  write_en,
  input  logic [AW-1:0]         wa,
  input  logic [XLEN-1:0]       wd,
  input  logic [NREAD*AW-1:0]   ra,
  output logic [NREAD*XLEN-1:0] rd,
  output logic                  ready,
  output logic                  clear_done
);

  logic [XLEN-1:0]             mem [DEPTH];
  logic                        clr_we;
  logic [AW-1:0]               clr_addr;
  logic                        wa_zero;
  logic                        wr_live;
  logic                        wr_commit;
  logic [NREAD-1:0][AW-1:0]    ra_v;
  logic [NREAD-1:0][XLEN-1:0]  rd_v;

  regfile_clear_fsm #(.DEPTH(DEPTH)) u_clear (
    .clk        (clk),
    .reset      (reset),
    .clear_req  (clear_req),
    .ready      (ready),
    .clear_done (clear_done),
    .clr_we     (clr_we),
    .clr_addr   (clr_addr)
  );

  assign wa_zero   = ZERO_REG && (wa == '0);
  assign wr_live   = ready && write_en && !wa_zero;
  // A clear request or reset in the same cycle wins over the port write.
  assign wr_commit = wr_live && !clear_req && !reset;

  always_ff @(posedge clk) begin
    if (clr_we)
      mem[clr_addr] <= '0;
    else if (wr_commit)
      mem[wa] <= wd;
  end

  assign ra_v = ra;
  assign rd   = rd_v;

  for (genvar i = 0; i < NREAD; i++) begin : g_rd
    logic ra_zero;
    logic hit;
    assign ra_zero = ZERO_REG && (ra_v[i] == '0);
    assign hit     = BYPASS && wr_live && (wa == ra_v[i]);
    assign rd_v[i] = (!ready || ra_zero) ? '0 :
                     hit                 ? wd :
                                           mem[ra_v[i]];
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: array model updated per edge, per-cycle compare, plus literal spot checks.
module tb_regfile_mp;
  localparam int XLEN  = 32;
  localparam int DEPTH = 32;
  localparam int NREAD = 3;
  localparam int AW    = 5;

  logic                  clk = 1'b0;
  logic                  reset = 1'b1;
  logic                  clear_req = 1'b0;
  logic                  write_en = 1'b0;
  logic [AW-1:0]         wa = '0;
  logic [XLEN-1:0]       wd = '0;
  logic [NREAD*AW-1:0]   ra = '0;
  logic [NREAD*XLEN-1:0] rd;
  logic                  ready;
  logic                  clear_done;

  regfile_mp #(.XLEN(XLEN), .DEPTH(DEPTH), .NREAD(NREAD), .BYPASS(1'b1), .ZERO_REG(1'b1)) dut (
    .clk(clk), .reset(reset), .clear_req(clear_req), .write_en(write_en),
    .wa(wa), .wd(wd), .ra(ra), .rd(rd), .ready(ready), .clear_done(clear_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  function automatic logic [XLEN-1:0] rd_port(input int i);
    return rd[i*XLEN +: XLEN];
  endfunction

  function automatic logic [AW-1:0] ra_port(input int i);
    return ra[i*AW +: AW];
  endfunction

  // Model: contents plus number of clear cycles still owed; reads are 0 until that reaches 0.
  logic [XLEN-1:0] m [DEPTH];
  int busy = DEPTH;

  initial foreach (m[k]) m[k] = '0;

  always @(posedge clk) begin
    if (reset) busy = DEPTH;
    else if (busy > 0) begin
      busy--;
      if (busy == 0) foreach (m[k]) m[k] = '0;
    end
    else if (clear_req) busy = DEPTH;
    else if (write_en && wa != 0) m[wa] = wd;
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("ready", {31'd0, ready}, {31'd0, busy == 0});
      chk("clear_done", {31'd0, clear_done}, {31'd0, (busy == 1) && !reset});
      for (int i = 0; i < NREAD; i++) begin
        logic [XLEN-1:0] e;
        logic [AW-1:0] a;
        a = ra_port(i);
        if (busy != 0 || a == 0) e = '0;
        else if (write_en && wa == a) e = wd;
        else e = m[a];
        chk($sformatf("rd%0d", i), rd_port(i), e);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Counts negedge samples with ready low, bounded so a stuck FSM cannot hang the run.
  task automatic wait_ready(output int n, output int pulses);
    n = 0;
    pulses = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (clear_done) pulses++;
      if (ready) break;
      n++;
    end
    #1;
  endtask

  int n, p, n0;

  initial begin
    // 1: reset two cycles, then the sweep
    step();
    chk_en = 1'b1;
    chk("reset_ready", {31'd0, ready}, 32'd0);
    step();
    reset = 1'b0;
    wait_ready(n, p);
    chk("t1_clear_len", n, 32);
    chk("t1_done_pulses", p, 1);
    ra = {5'd3, 5'd2, 5'd1};
    @(negedge clk);
    chk("t1_rd0", rd_port(0), 0);
    chk("t1_rd2", rd_port(2), 0);

    // 2: ordinary writes and multi-port reads
    step();
    write_en = 1'b1; wa = 5'd1; wd = 32'd42;
    step();
    wa = 5'd2; wd = 32'd100;
    step();
    write_en = 1'b0;
    ra = {5'd1, 5'd2, 5'd1};
    @(negedge clk);
    chk("t2_x1", rd_port(0), 42);
    chk("t2_x2", rd_port(1), 100);
    chk("t2_port2", rd_port(2), 42);

    // 3: x0 stays zero
    step();
    write_en = 1'b1; wa = 5'd0; wd = 32'd999; ra = {5'd0, 5'd0, 5'd0};
    @(negedge clk);
    chk("t3_x0_same", rd_port(0), 0);
    step();
    write_en = 1'b0;
    @(negedge clk);
    chk("t3_x0_next", rd_port(0), 0);

    // 4: bypass on two ports at once
    step();
    write_en = 1'b1; wa = 5'd5; wd = 32'd7; ra = {5'd1, 5'd5, 5'd5};
    @(negedge clk);
    chk("t4_byp0", rd_port(0), 7);
    chk("t4_byp1", rd_port(1), 7);
    step();
    write_en = 1'b0;
    @(negedge clk);
    chk("t4_stored", rd_port(0), 7);

    // 5: clear_req beats a same-cycle write
    step();
    write_en = 1'b1; wa = 5'd3; wd = 32'd200;
    step();
    clear_req = 1'b1; wa = 5'd4; wd = 32'd55;
    step();
    clear_req = 1'b0; write_en = 1'b0;
    ra = {5'd1, 5'd4, 5'd3};
    wait_ready(n, p);
    chk("t5_clear_len", n, 32);
    chk("t5_done_pulses", p, 1);
    @(negedge clk);
    chk("t5_x3", rd_port(0), 0);
    chk("t5_x4", rd_port(1), 0);
    chk("t5_x1", rd_port(2), 0);

    // 6: reset on clear cycle 10 restarts the sweep; writes during it are lost
    step();
    clear_req = 1'b1;
    step();
    clear_req = 1'b0;
    write_en = 1'b1; wa = 5'd6; wd = 32'd77;
    repeat (10) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    n0 = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (!ready) n0++;
      wa = AW'(6 + (k % 4));
      step();
    end
    write_en = 1'b0;
    wait_ready(n, p);
    chk("t6_restart_len", n0 + n, 32);
    ra = {5'd8, 5'd7, 5'd6};
    @(negedge clk);
    chk("t6_x6", rd_port(0), 0);
    chk("t6_x7", rd_port(1), 0);
    chk("t6_x8", rd_port(2), 0);

    step();
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
